entrada_salida_n: RTL and testbench
===================================

Name: entrada_salida_n

Overview:
- Parametrised successor to the CPU-side I/O port controller.
- Connects the processor's I/O access bus to NUM_DEV external devices.
- Each device has a registered output latch with a write strobe, and a 2-flop synchronised input with a change-detect flag.
- A status register and an interrupt-mask register provide polled or interrupt-driven input; a registered read path returns data with a valid pulse.

Parameters:
NUM_DEV, 5, number of device channels (1..32)
DATA_W, 8, data width per device and of the CPU data bus (DATA_W >= NUM_DEV)
ADDR_W, 7, CPU address width; must satisfy 2^ADDR_W >= NUM_DEV+2

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-low reset
activarEntradaSalida  in  1  access request, sampled each rising edge
escribirEntradaSalida  in  1  1 = write, 0 = read; qualified by activarEntradaSalida
direccionEntradaSalida  in  ADDR_W  access address
entradaEntradaSalida  in  DATA_W  CPU write data
salidaEntradaSalida  out  DATA_W  registered read data
salidaValida  out  1  one-cycle pulse: salidaEntradaSalida holds read result
errorDireccion  out  1  one-cycle pulse: access to unmapped address
entradaDispositivos  in  NUM_DEV*DATA_W  device inputs, asynchronous to clk, device i at [i*DATA_W +: DATA_W]
salidaDispositivos  out  NUM_DEV*DATA_W  device output latches, same packing
strobeEscritura  out  NUM_DEV  one-cycle pulse per device on write
interrupcion  out  1  level: OR over (cambio & mascara)

Behaviour:
- Reset (reset=0, asynchronous): all output latches, sync stages, cambio flags, mascara, salidaEntradaSalida → 0; salidaValida, errorDireccion, strobeEscritura → 0.
- Address map: 0..NUM_DEV-1 = device i; NUM_DEV = STATUS; NUM_DEV+1 = MASK; all higher addresses unmapped.
- Input path: per device, sync1 → sync2 → prev registers. cambio[i] is set in any cycle where sync2 != prev. Input-to-visible latency is 2 cycles.
- Write to device i: salidaDispositivos[i] ← entradaEntradaSalida at the same edge; strobeEscritura[i]=1 for exactly that following cycle. Back-to-back writes produce back-to-back strobes. The latch holds until the next write (unlike the legacy zeroing mux).
- Write to STATUS: write-1-to-clear cambio bits [NUM_DEV-1:0]; upper bits ignored.
- Write to MASK: mascara ← entradaEntradaSalida[NUM_DEV-1:0].
- Read: result is registered at the access edge.
  - salidaValida=1 for the next cycle.
  - salidaEntradaSalida holds its value until the next read; it is not zeroed.
  - Read latency is 1 cycle.
- Read device i: returns sync2[i] as sampled at the access edge, and clears cambio[i].
- Read STATUS: returns cambio zero-extended to DATA_W. It does not clear flags.
- Read MASK: returns mascara zero-extended.
- Unmapped access (read or write):
  - errorDireccion=1 for one cycle; no state changes.
  - On a read, salidaEntradaSalida ← 0 and salidaValida=1.
- Simultaneous set and clear of cambio[i] in the same cycle (by read or W1C): set wins and the flag remains 1.
- activarEntradaSalida=0: no side effects; escribir and direccion are don't-care.
- interrupcion: combinational from registered cambio and mascara, so it updates the cycle after a flag or mask edge.
- Reset asserted mid-access: the access is dropped and no strobe is issued. After release, the first edge with activar=1 is serviced normally.

Decomposition:
- Shared package/include:
  - address-offset constants (STATUS_OFS = NUM_DEV, MASK_OFS = NUM_DEV+1), expressed as functions of NUM_DEV;
  - the clog2 helper used for ADDR_W checks.
- Sub-module sincronizador_cambio (width DATA_W): 2-flop synchroniser plus prev register, outputs the synced value and a change pulse. Instantiated NUM_DEV times via generate.
- Top level holds the address decode, output latches, cambio/mascara registers and the read mux.

Test Plan:
- Reset, then write 0xA5 to addr 2 → salidaDispositivos[2]=0xA5 next cycle, strobeEscritura=5'b00100 for 1 cycle; other latches remain 0; the value holds after a later write to addr 3.
- Drive device 1 input 0x3C, wait 3 cycles → STATUS read returns 0x02 with salidaValida 1 cycle after request; read addr 1 returns 0x3C; a subsequent STATUS read returns 0x00.
- Write MASK=0x01, toggle device 0 input 0x00→0xFF → interrupcion rises 3 cycles later; STATUS W1C 0x01 → interrupcion falls the next cycle.
- Issue a read of addr 0 in the same cycle device 0's sync2 changes → cambio[0] remains 1 afterwards (set wins).
- Access addr 0x7F (read and write) → errorDireccion pulse each time, read data 0x00 with salidaValida=1, no latch, flag or mask change.
- Assert reset mid-stream between a write request and the following edge → all outputs 0 immediately (asynchronous), no strobe; normal operation after deassert.

Source files
------------

// File: rtl/entrada_salida_n_pkg.sv
// Shared address-map helpers and the clog2 used to check the address width.
package entrada_salida_n_pkg;

    function automatic int status_ofs(input int num_dev);
        return num_dev;
    endfunction

    function automatic int mask_ofs(input int num_dev);
        return num_dev + 32'sd1;
    endfunction

    function automatic int clog2(input int value);
        int bits;
        bits = 32'sd0;
        for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 1) begin
            bits = bits + 32'sd1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/entrada_salida_n_sincronizador_cambio.sv
// Two-flop synchroniser for one device input, with a previous-value register
// so a change pulse is raised for every cycle the synchronised value moves.
module entrada_salida_n_sincronizador_cambio #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] entrada,
    output logic [WIDTH-1:0] sincronizada,
    output logic             cambio
);

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] prev_r;

    // Synchroniser chain and previous-value history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= '0;
            sync2_r <= '0;
            prev_r  <= '0;
        end else begin
            sync1_r <= entrada;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign sincronizada = sync2_r;
    assign cambio       = (sync2_r != prev_r);

endmodule

// File: rtl/entrada_salida_n.sv
// CPU-side I/O port controller: per-device output latches with write strobes,
// synchronised inputs with change flags, status/mask registers and a read path.
module entrada_salida_n
    import entrada_salida_n_pkg::*;
#(
    parameter int NUM_DEV = 5,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      activarEntradaSalida,
    input  logic                      escribirEntradaSalida,
    input  logic [ADDR_W-1:0]         direccionEntradaSalida,
    input  logic [DATA_W-1:0]         entradaEntradaSalida,
    output logic [DATA_W-1:0]         salidaEntradaSalida,
    output logic                      salidaValida,
    output logic                      errorDireccion,
    input  logic [NUM_DEV*DATA_W-1:0] entradaDispositivos,
    output logic [NUM_DEV*DATA_W-1:0] salidaDispositivos,
    output logic [NUM_DEV-1:0]        strobeEscritura,
    output logic                      interrupcion
);

    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(status_ofs(NUM_DEV));
    localparam logic [ADDR_W-1:0] MASK_ADDR   = ADDR_W'(mask_ofs(NUM_DEV));

    if ((NUM_DEV < 1) || (NUM_DEV > 32) || (NUM_DEV > DATA_W) ||
        (clog2(NUM_DEV + 2) > ADDR_W)) begin : g_bad_param
        $error("entrada_salida_n: inconsistent NUM_DEV/DATA_W/ADDR_W");
    end

    logic [NUM_DEV*DATA_W-1:0] sync_bus_s;
    logic [NUM_DEV-1:0]        set_s;

    for (genvar g = 0; g < NUM_DEV; g++) begin : g_dev
        entrada_salida_n_sincronizador_cambio #(
            .WIDTH (DATA_W)
        ) u_sinc (
            .clk          (clk),
            .reset        (reset),
            .entrada      (entradaDispositivos[g*DATA_W +: DATA_W]),
            .sincronizada (sync_bus_s[g*DATA_W +: DATA_W]),
            .cambio       (set_s[g])
        );
    end

    logic [NUM_DEV*DATA_W-1:0] latch_r;
    logic [NUM_DEV-1:0]        strobe_r;
    logic [NUM_DEV-1:0]        cambio_r;
    logic [NUM_DEV-1:0]        mascara_r;
    logic [DATA_W-1:0]         rdata_r;
    logic                      valid_r;
    logic                      error_r;

    logic [NUM_DEV-1:0] wr_dev_s;
    logic [NUM_DEV-1:0] rd_dev_s;
    logic [DATA_W-1:0]  dev_rdata_s;
    logic               rd_status_s;
    logic               wr_status_s;
    logic               rd_mask_s;
    logic               wr_mask_s;
    logic               unmapped_s;
    logic               rd_any_s;
    logic [NUM_DEV-1:0] clr_s;
    logic [NUM_DEV-1:0] cambio_next_s;
    logic [DATA_W-1:0]  rdata_next_s;

    // Address decode, flag update (set beats clear) and read-data selection.
    always_comb begin
        wr_dev_s    = '0;
        rd_dev_s    = '0;
        dev_rdata_s = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            wr_dev_s[i] = activarEntradaSalida && escribirEntradaSalida &&
                          (direccionEntradaSalida == ADDR_W'(i));
            rd_dev_s[i] = activarEntradaSalida && !escribirEntradaSalida &&
                          (direccionEntradaSalida == ADDR_W'(i));
            dev_rdata_s = dev_rdata_s |
                          ({DATA_W{rd_dev_s[i]}} & sync_bus_s[i*DATA_W +: DATA_W]);
        end

        rd_status_s = activarEntradaSalida && !escribirEntradaSalida &&
                      (direccionEntradaSalida == STATUS_ADDR);
        wr_status_s = activarEntradaSalida && escribirEntradaSalida &&
                      (direccionEntradaSalida == STATUS_ADDR);
        rd_mask_s   = activarEntradaSalida && !escribirEntradaSalida &&
                      (direccionEntradaSalida == MASK_ADDR);
        wr_mask_s   = activarEntradaSalida && escribirEntradaSalida &&
                      (direccionEntradaSalida == MASK_ADDR);
        unmapped_s  = activarEntradaSalida && (direccionEntradaSalida > MASK_ADDR);
        rd_any_s    = activarEntradaSalida && !escribirEntradaSalida;

        clr_s = rd_dev_s | ({NUM_DEV{wr_status_s}} & entradaEntradaSalida[NUM_DEV-1:0]);
        cambio_next_s = (cambio_r & ~clr_s) | set_s;

        if (|rd_dev_s) begin
            rdata_next_s = dev_rdata_s;
        end else if (rd_status_s) begin
            rdata_next_s = DATA_W'(cambio_r);
        end else if (rd_mask_s) begin
            rdata_next_s = DATA_W'(mascara_r);
        end else begin
            rdata_next_s = '0;
        end
    end

    // Architectural state: latches, flags, mask and the registered read port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            latch_r   <= '0;
            strobe_r  <= '0;
            cambio_r  <= '0;
            mascara_r <= '0;
            rdata_r   <= '0;
            valid_r   <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            cambio_r <= cambio_next_s;
            strobe_r <= wr_dev_s;
            error_r  <= unmapped_s;
            valid_r  <= rd_any_s;
            if (wr_mask_s) begin
                mascara_r <= entradaEntradaSalida[NUM_DEV-1:0];
            end
            if (rd_any_s) begin
                rdata_r <= rdata_next_s;
            end
            for (int i = 0; i < NUM_DEV; i++) begin
                if (wr_dev_s[i]) begin
                    latch_r[i*DATA_W +: DATA_W] <= entradaEntradaSalida;
                end
            end
        end
    end

    assign salidaDispositivos  = latch_r;
    assign strobeEscritura     = strobe_r;
    assign salidaEntradaSalida = rdata_r;
    assign salidaValida        = valid_r;
    assign errorDireccion      = error_r;
    assign interrupcion        = |(cambio_r & mascara_r);

endmodule

// File: tb/tb_entrada_salida_n.sv
// Self-checking bench: directed scenarios plus random traffic against a
// latency-based reference model of the I/O controller.
module tb_entrada_salida_n;

    localparam int ND = 5;
    localparam int DW = 8;
    localparam int AW = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic             activar;
    logic             escribir;
    logic [AW-1:0]    direccion;
    logic [DW-1:0]    wdata;
    logic [DW-1:0]    rdata;
    logic             valida;
    logic             err;
    logic [ND*DW-1:0] dev_bus;
    logic [ND*DW-1:0] dev_out;
    logic [ND-1:0]    strobe;
    logic             irq;

    always #5 clk = ~clk;

    entrada_salida_n #(.NUM_DEV(ND), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .activarEntradaSalida   (activar),
        .escribirEntradaSalida  (escribir),
        .direccionEntradaSalida (direccion),
        .entradaEntradaSalida   (wdata),
        .salidaEntradaSalida    (rdata),
        .salidaValida           (valida),
        .errorDireccion         (err),
        .entradaDispositivos    (dev_bus),
        .salidaDispositivos     (dev_out),
        .strobeEscritura        (strobe),
        .interrupcion           (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: in_hist[k] is the device input that was present k edges ago.
    logic [DW-1:0] dev_in  [ND];
    logic [DW-1:0] in_hist [4][ND];
    logic [DW-1:0] lat_m   [ND];
    logic [ND-1:0] cam_m, mask_m, strobe_m;
    logic [DW-1:0] rdata_m;
    logic          valid_m, err_m;

    task automatic model_reset();
        for (int k = 0; k < 4; k++) for (int i = 0; i < ND; i++) in_hist[k][i] = 8'h00;
        for (int i = 0; i < ND; i++) lat_m[i] = 8'h00;
        cam_m = '0; mask_m = '0; strobe_m = '0;
        rdata_m = 8'h00; valid_m = 1'b0; err_m = 1'b0;
    endtask

    task automatic model_edge(input logic act, input logic wr, input logic [AW-1:0] a,
                              input logic [DW-1:0] d);
        logic [ND-1:0] set_v, clr_v;
        int ad;
        for (int k = 3; k > 0; k--) in_hist[k] = in_hist[k-1];
        for (int i = 0; i < ND; i++) in_hist[0][i] = dev_in[i];
        // visible value is the input from two edges ago; a flag sets when it moved
        for (int i = 0; i < ND; i++) set_v[i] = (in_hist[2][i] != in_hist[3][i]);
        clr_v = '0; strobe_m = '0; valid_m = 1'b0; err_m = 1'b0;
        ad = int'(a);
        if (act) begin
            if (ad < ND) begin
                if (wr) begin lat_m[ad] = d; strobe_m[ad] = 1'b1; end
                else begin rdata_m = in_hist[2][ad]; clr_v[ad] = 1'b1; valid_m = 1'b1; end
            end else if (ad == ND) begin
                if (wr) clr_v = d[ND-1:0];
                else begin rdata_m = DW'(cam_m); valid_m = 1'b1; end
            end else if (ad == ND + 1) begin
                if (wr) mask_m = d[ND-1:0];
                else begin rdata_m = DW'(mask_m); valid_m = 1'b1; end
            end else begin
                err_m = 1'b1;
                if (!wr) begin rdata_m = 8'h00; valid_m = 1'b1; end
            end
        end
        cam_m = (cam_m & ~clr_v) | set_v;
    endtask

    task automatic compare_all();
        logic [ND*DW-1:0] lat_p;
        for (int i = 0; i < ND; i++) lat_p[i*DW +: DW] = lat_m[i];
        check_val("latches", dev_out, lat_p);
        check_val("strobe", strobe, strobe_m);
        check_val("valid", valida, valid_m);
        check_val("error", err, err_m);
        check_val("rdata", rdata, rdata_m);
        check_val("irq", irq, |(cam_m & mask_m));
    endtask

    task automatic step(input logic act, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        @(negedge clk);
        reset = 1'b1; activar = act; escribir = wr; direccion = a; wdata = d;
        for (int i = 0; i < ND; i++) dev_bus[i*DW +: DW] = dev_in[i];
        @(posedge clk);
        model_edge(act, wr, a, d);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 7'h00, 8'h00);
    endtask

    initial begin
        reset = 1'b0; activar = 1'b0; escribir = 1'b0; direccion = '0; wdata = '0;
        dev_bus = '0;
        for (int i = 0; i < ND; i++) dev_in[i] = 8'h00;
        model_reset();
        #3;
        compare_all();
        repeat (2) @(posedge clk);

        // write latch 2, then latch 3; latch 2 must hold
        step(1'b1, 1'b1, 7'd2, 8'hA5);
        check_val("wr2_latch", dev_out[2*DW +: DW], 8'hA5);
        check_val("wr2_strobe", strobe, 5'b00100);
        step(1'b1, 1'b1, 7'd3, 8'h5A);
        check_val("wr2_hold", dev_out[2*DW +: DW], 8'hA5);
        check_val("wr3_strobe", strobe, 5'b01000);
        idle(1);
        check_val("strobe_idle", strobe, 5'b00000);

        // input change on device 1 -> status, data read, status cleared
        dev_in[1] = 8'h3C;
        idle(3);
        step(1'b1, 1'b0, 7'd5, 8'h00);
        check_val("status_dev1", rdata, 8'h02);
        check_val("status_valid", valida, 1'b1);
        step(1'b1, 1'b0, 7'd1, 8'h00);
        check_val("read_dev1", rdata, 8'h3C);
        step(1'b1, 1'b0, 7'd5, 8'h00);
        check_val("status_clr", rdata, 8'h00);

        // interrupt on masked device 0, cleared via W1C
        step(1'b1, 1'b1, 7'd6, 8'h01);
        dev_in[0] = 8'hFF;
        idle(2);
        check_val("irq_early", irq, 1'b0);
        idle(1);
        check_val("irq_rise", irq, 1'b1);
        step(1'b1, 1'b1, 7'd5, 8'h01);
        check_val("irq_fall", irq, 1'b0);

        // read device 0 in the cycle its synchronised value moves: set wins
        idle(2);
        dev_in[0] = 8'h55;
        idle(2);
        step(1'b1, 1'b0, 7'd0, 8'h00);
        check_val("setwin_data", rdata, 8'h55);
        step(1'b1, 1'b0, 7'd5, 8'h00);
        check_val("setwin_flag", rdata, 8'h01);
        step(1'b1, 1'b1, 7'd5, 8'h1F);

        // unmapped read and write
        step(1'b1, 1'b0, 7'h7F, 8'h00);
        check_val("unmap_rd_err", err, 1'b1);
        check_val("unmap_rd_data", rdata, 8'h00);
        check_val("unmap_rd_valid", valida, 1'b1);
        step(1'b1, 1'b1, 7'h7F, 8'hFF);
        check_val("unmap_wr_err", err, 1'b1);
        check_val("unmap_wr_strobe", strobe, 5'b00000);

        // asynchronous reset between a write request and its edge
        @(negedge clk);
        activar = 1'b1; escribir = 1'b1; direccion = 7'd4; wdata = 8'hC3;
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_val("rst_latches", dev_out, 40'h0);
        check_val("rst_strobe", strobe, 5'b00000);
        compare_all();
        step(1'b1, 1'b1, 7'd4, 8'hC3);
        check_val("post_rst_latch", dev_out[4*DW +: DW], 8'hC3);
        check_val("post_rst_strobe", strobe, 5'b10000);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic          act_r, wr_r;
            logic [AW-1:0] a_r;
            if ($urandom_range(0, 7) == 0) dev_in[$urandom_range(0, ND - 1)] = DW'($urandom);
            act_r = ($urandom_range(0, 3) != 0);
            wr_r  = $urandom_range(0, 1) == 1;
            a_r   = ($urandom_range(0, 15) == 0) ? 7'h7F : AW'($urandom_range(0, ND + 2));
            step(act_r, wr_r, a_r, DW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
